// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier result path: FSM state encodings,
// default widths and a small sizing helper.
package booth_pkg;

  localparam int PW_DEF = 8;
  localparam int ND_DEF = 3;
  localparam int DIG_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    CONV = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Bit-counter width able to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_bcd_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module booth_bcd_adj3
  import booth_pkg::*;
(
  input  logic [DIG_W-1:0] din,
  output logic [DIG_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= DIG_W'(5)) begin
      dout = din + DIG_W'(3);
    end
  end

endmodule

// File: rtl/booth_result_bcd.sv
// Captures a signed Booth product and converts it to sign + BCD by sequential double-dabble.
// Optional feature: define BOOTH_BCD_SKID_EN for a one-entry skid buffer in front of the converter.
module booth_result_bcd
  import booth_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int ND = ND_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PW-1:0]       prod,
  input  logic                prod_vld,
  input  logic                out_rdy,
  output logic                out_vld,
  output logic                out_sign,
  output logic [DIG_W*ND-1:0] out_bcd,
  output logic                busy,
  output logic                drop_err
);

  localparam int             BW   = DIG_W * ND;
  localparam int             CW   = cnt_width(PW);
  localparam logic [CW-1:0]  LAST = CW'(PW - 1);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    work;
  logic [BW-1:0]    bcd;
  logic [CW-1:0]    bit_cnt;
  logic             sign_q;
  logic             out_sign_q;
  logic [BW-1:0]    out_bcd_q;
  logic             drop_err_q;

  logic             load_work;
  logic [PW-1:0]    load_val;
  logic             drop;

  logic [BW-1:0]    bcd_adj;
  logic [BW+PW-1:0] sr_next;

`ifdef BOOTH_BCD_SKID_EN
  logic             skid_full;
  logic [PW-1:0]    skid_data;
  logic             skid_store;
  logic             skid_drain;
`endif

  for (genvar g = 0; g < ND; g++) begin : g_adj
    booth_bcd_adj3 u_adj (
      .din  (bcd[g*DIG_W +: DIG_W]),
      .dout (bcd_adj[g*DIG_W +: DIG_W])
    );
  end

  // One double-dabble step: the magnitude MSB shifts into the corrected BCD LSB.
  assign sr_next = {bcd_adj, work} << 1;

  always_comb begin
    state_nxt = state;
    load_work = 1'b0;
    load_val  = prod;
    drop      = 1'b0;
`ifdef BOOTH_BCD_SKID_EN
    skid_store = 1'b0;
    skid_drain = 1'b0;
`endif

    case (state)
      IDLE: begin
`ifdef BOOTH_BCD_SKID_EN
        if (skid_full) begin
          state_nxt  = ABS;
          load_work  = 1'b1;
          load_val   = skid_data;
          skid_drain = 1'b1;
        end else
`endif
        if (prod_vld) begin
          state_nxt = ABS;
          load_work = 1'b1;
          load_val  = prod;
        end
      end
      ABS: state_nxt = CONV;
      CONV: begin
        if (bit_cnt == LAST) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_rdy) begin
          state_nxt = IDLE;
`ifdef BOOTH_BCD_SKID_EN
          if (skid_full) begin
            state_nxt  = ABS;
            load_work  = 1'b1;
            load_val   = skid_data;
            skid_drain = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A pulse that does not start a conversion this cycle is buffered or discarded.
`ifdef BOOTH_BCD_SKID_EN
    if (prod_vld && !(state == IDLE && !skid_full)) begin
      if (!skid_full || skid_drain) begin
        skid_store = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
`else
    if (prod_vld && state != IDLE) begin
      drop = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      work       <= '0;
      bcd        <= '0;
      bit_cnt    <= '0;
      sign_q     <= 1'b0;
      out_sign_q <= 1'b0;
      out_bcd_q  <= '0;
      drop_err_q <= 1'b0;
`ifdef BOOTH_BCD_SKID_EN
      skid_full  <= 1'b0;
      skid_data  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (drop) begin
        drop_err_q <= 1'b1;
      end
      if (load_work) begin
        work <= load_val;
      end
      case (state)
        ABS: begin
          // Negating the most negative value wraps to 2^(PW-1), which is the correct unsigned magnitude.
          sign_q  <= work[PW-1];
          work    <= work[PW-1] ? (~work + 1'b1) : work;
          bcd     <= '0;
          bit_cnt <= '0;
        end
        CONV: begin
          {bcd, work} <= sr_next;
          bit_cnt     <= bit_cnt + 1'b1;
          if (bit_cnt == LAST) begin
            out_bcd_q  <= sr_next[PW +: BW];
            out_sign_q <= sign_q;
          end
        end
        default: ;
      endcase
`ifdef BOOTH_BCD_SKID_EN
      if (skid_store) begin
        skid_data <= prod;
        skid_full <= 1'b1;
      end else if (skid_drain) begin
        skid_full <= 1'b0;
      end
`endif
    end
  end

  assign out_vld  = (state == HOLD);
  assign busy     = (state != IDLE);
  assign out_sign = out_sign_q;
  assign out_bcd  = out_bcd_q;
  assign drop_err = drop_err_q;

endmodule
